// File: rtl/edabk_uart_fifo_lvl.sv
// edabk_uart_fifo_lvl: level-reporting synchronous FIFO for the UART TX/RX paths.
// Show-ahead read port, occupancy count, registered watermark flags, and a
// read+write on full that keeps the FIFO full without losing data.
// Optional sticky overflow/underflow flags (with clear_err) are built only when
// the macro EDABK_FIFO_ERR_FLAG_EN is defined.

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_uart_fifo_lvl #(
    parameter int DATA_WIDTH    = `CFG_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = 4,
    parameter int AFULL_THRESH  = 2**ADDRESS_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic                    read,
    input  logic                    flush,
`ifdef EDABK_FIFO_ERR_FLAG_EN
    input  logic                    clear_err,
    output logic                    overflow,
    output logic                    underflow,
`endif
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [ADDRESS_WIDTH:0]  level
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L   = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AFULL_L   = (ADDRESS_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDRESS_WIDTH:0] AEMPTY_L  = (ADDRESS_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDRESS_WIDTH:0]   level_q, level_d;
    logic                     empty_q, full_q, aempty_q, afull_q;
    logic                     rd_en, wr_en, mem_we;

    // Accept/reject decisions and next-state pointers and level; flush wins.
    always_comb begin
        rd_en   = read & ~empty_q;
        wr_en   = write & (~full_q | rd_en);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        mem_we  = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + ADDRESS_WIDTH'(1);
                mem_we = 1'b1;
            end
            if (rd_en) begin
                rptr_d = rptr_q + ADDRESS_WIDTH'(1);
            end
            if (wr_en && !rd_en) begin
                level_d = level_q + (ADDRESS_WIDTH+1)'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - (ADDRESS_WIDTH+1)'(1);
            end
        end
    end

    // Pointers, level and flags; flags are derived from the next level so
    // they change on the same edge as the level itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == DEPTH_L);
            aempty_q <= (level_d <= AEMPTY_L);
            afull_q  <= (level_d >= AFULL_L);
        end
    end

    // Storage array: written on accepted pushes only, never cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= write_data;
        end
    end

    assign read_data    = empty_q ? '0 : mem_q[rptr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign level        = level_q;

`ifdef EDABK_FIFO_ERR_FLAG_EN
    logic ovf_q, udf_q;
    logic ovf_set, udf_set;

    // Error events: a push lost to a full FIFO, a pop from an empty one.
    always_comb begin
        ovf_set = write & full_q & ~rd_en & ~flush;
        udf_set = read & empty_q & ~write;
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clear_err) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (clear_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: doc/edabk_uart_fifo_lvl.md
# edabk_uart_fifo_lvl

Parametrised, level-reporting synchronous FIFO for the UART transceiver TX and RX data paths; successor to the byte FIFO. It adds configurable depth, an occupancy count, programmable almost-full/almost-empty watermarks, legal read+write on full, and optional sticky overflow/underflow error flags. It sits between the bus-side register interface and the UART shift engines, one instance per direction.

## Interface
- DATA_WIDTH, `CFG_DATA_WIDTH`: bits per entry.
- ADDRESS_WIDTH, 4: pointer width; depth DEPTH = 2**ADDRESS_WIDTH; legal range 1..10.
- AFULL_THRESH, 2**ADDRESS_WIDTH-2: almost_full asserted when level >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserted when level <= AEMPTY_THRESH; legal range 0..DEPTH-1.

- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- write  input  1  push request.
- read  input  1  pop request; read_data is consumed on the same edge.
- flush  input  1  synchronous clear of all contents.
- clear_err  input  1  synchronous clear of the sticky error flags; present only with the macro.
- write_data  input  DATA_WIDTH  data to push.
- read_data  output  DATA_WIDTH  head entry (show-ahead), combinational from registered state.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- almost_empty  output  1  level <= AEMPTY_THRESH.
- almost_full  output  1  level >= AFULL_THRESH.
- level  output  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full and not popped; present only with the macro.
- underflow  output  1  sticky: read attempted while empty; present only with the macro.

## Operation
- State: write_ptr and read_ptr (ADDRESS_WIDTH bits, reset 0, wrap DEPTH-1 -> 0 naturally), level register (ADDRESS_WIDTH+1 bits, reset 0), storage array (not reset).
- rd_en = read & ~empty. wr_en = write & (~full | rd_en).
- Level update: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- Storage: on wr_en, mem[write_ptr] <= write_data. Storage is not cleared on read or flush.
- read_data = empty ? 0 : mem[read_ptr].
- Flush has priority over write and read in the same cycle. Pointers and level go to 0. Pending write/read are dropped. Error flags are unaffected.
- Empty with write+read: the read is ignored (no underflow), and the write is accepted.
- Full with write+read: both are accepted, level stays DEPTH, and no overflow is flagged.
- Reset values: empty=1, full=0, almost_empty=1 (since AEMPTY_THRESH>=0), almost_full=0, level=0, read_data=0, overflow=0, underflow=0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous reset), and contents are discarded.

## Timing
- All flags and level are registered. They are computed from the next-state level and update on the same edge as the pointers. There is no combinational path from write/read to any output.
- Write-to-read latency: data written at edge N is on read_data, with empty=0, after edge N.
- A pop at edge N presents the next entry on read_data after edge N.
- Flags take effect after the edge that changes level. Watermark comparisons use the unsigned ADDRESS_WIDTH+1-bit level.

## Configuration
- Macro: EDABK_FIFO_ERR_FLAG_EN.
- When defined:
  - overflow sets on write & full & ~rd_en & ~flush.
  - underflow sets on read & empty & ~write.
  - Both flags hold until clear_err or reset.
  - If clear_err and a set event occur in the same cycle, the set wins.
- When undefined: the clear_err, overflow and underflow ports are absent, and no error logic is built. All other behaviour is identical.

## Test plan
Configuration for all scenarios: DATA_WIDTH=8, ADDRESS_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1, macro defined.

- **Reset:** hold reset 2 cycles -> level=0, empty=1, almost_empty=1, full=0, almost_full=0, read_data=0x00, overflow=0, underflow=0.
- **Fill and wrap:**
  - Stimulus: write 0x11,0x22,0x33,0x44; then read 2; then write 0x55,0x66; then read 4.
  - Level sequence: 1,2,3,4 (almost_full at 3, full at 4); then 3,2; then 3,4; then 3,2,1,0.
  - read order: 0x11,0x22,0x33,0x44,0x55,0x66, exercising pointer wrap.
- **Full with read+write:** from full [0xA0..0xA3], assert write=1 (0xB0) and read=1 for one cycle -> level stays 4, read_data=0xA1, overflow=0. Tail is 0xB0 after 3 further reads.
- **Overflow and underflow:**
  - Write while full (no read) -> level=4, contents unchanged, overflow=1 next cycle.
  - Read while empty -> underflow=1, level=0.
  - clear_err -> both flags 0 after one edge.
  - clear_err concurrent with a new overflow -> overflow stays 1.
- **Flush priority:** level=3, assert flush+write+read -> next cycle level=0, empty=1, read_data=0x00, no flag change. A subsequent write of 0x77 -> read_data=0x77.
- **Async reset mid-stream:** assert reset between edges with level=2 -> outputs reach their reset values before the next edge. After release, first write 0x5A is read back as 0x5A.
